// File: rtl/viterbi_ber_checker.sv
// Bit-error scoreboard for a conv-encoder/Viterbi-decoder chain: reference FIFO delay line,
// start-up skip, in-order compare, saturating stats. Optional burst stats via BER_BURST_STATS_EN.
module viterbi_ber_checker #(
    parameter int DEPTH  = 2048,
    parameter int CNT_W  = 16,
    parameter int SKIP_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [SKIP_W-1:0] skip_i,
    input  logic [CNT_W-1:0]  num_check_i,
    input  logic              ref_valid_i,
    input  logic              ref_bit_i,
    input  logic              dec_valid_i,
    input  logic              dec_bit_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  good_o,
    output logic [CNT_W-1:0]  bad_o,
    output logic              mismatch_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic [CNT_W-1:0]  max_burst_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

    state_t            state;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [SKIP_W-1:0] skip_cnt;
    logic [CNT_W-1:0]  num_check, cmp_cnt, cmp_cnt_nxt;
    logic              mem [DEPTH];

    logic fifo_empty, fifo_full, stats_clr;
    logic accept_ref, pop_req, do_push, do_pop, do_cmp, ref_sel, cmp_miss;

    // An empty pop with a same-cycle push bypasses the FIFO and compares the live reference bit.
    always_comb begin
        fifo_empty  = (wr_ptr == rd_ptr);
        fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        stats_clr   = !abort_i && start_i && (state == IDLE || state == DONE);
        accept_ref  = !abort_i && ref_valid_i && (state == ALIGN || state == RUN);
        pop_req     = !abort_i && dec_valid_i && (state == RUN);
        do_pop      = pop_req && !fifo_empty;
        do_cmp      = pop_req && (!fifo_empty || ref_valid_i);
        do_push     = accept_ref && !(pop_req && fifo_empty) && (!fifo_full || do_pop);
        ref_sel     = fifo_empty ? ref_bit_i : mem[rd_ptr[AW-1:0]];
        cmp_miss    = (ref_sel != dec_bit_i);
        cmp_cnt_nxt = cmp_cnt + 1'b1;
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= ref_bit_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            good_o      <= '0;
            bad_o       <= '0;
            mismatch_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            skip_cnt    <= '0;
            num_check   <= '0;
            cmp_cnt     <= '0;
        end else begin
            mismatch_o <= 1'b0;
            if (abort_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: if (start_i) begin
                        good_o      <= '0;
                        bad_o       <= '0;
                        overflow_o  <= 1'b0;
                        underflow_o <= 1'b0;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        cmp_cnt     <= '0;
                        skip_cnt    <= skip_i;
                        num_check   <= num_check_i;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        state       <= (skip_i == '0) ? RUN : ALIGN;
                    end
                    ALIGN: if (dec_valid_i) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (skip_cnt == SKIP_W'(1)) state <= RUN;
                    end
                    RUN: if (do_cmp) begin
                        cmp_cnt    <= cmp_cnt_nxt;
                        mismatch_o <= cmp_miss;
                        if (cmp_miss) begin
                            if (bad_o != CNT_MAX) bad_o <= bad_o + 1'b1;
                        end else begin
                            if (good_o != CNT_MAX) good_o <= good_o + 1'b1;
                        end
                        if (num_check != '0 && cmp_cnt_nxt == num_check) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
                // Pushes/pops only happen in ALIGN/RUN, so they never collide with the start flush.
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                if (accept_ref && fifo_full && !pop_req) overflow_o <= 1'b1;
                if (pop_req && fifo_empty && !ref_valid_i) underflow_o <= 1'b1;
            end
        end
    end

`ifdef BER_BURST_STATS_EN
    logic [CNT_W-1:0] cur_burst, cur_burst_nxt;

    assign cur_burst_nxt = (cur_burst == CNT_MAX) ? cur_burst : cur_burst + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_burst   <= '0;
            max_burst_o <= '0;
        end else if (stats_clr) begin
            cur_burst   <= '0;
            max_burst_o <= '0;
        end else if (do_cmp) begin
            if (cmp_miss) begin
                cur_burst <= cur_burst_nxt;
                if (cur_burst_nxt > max_burst_o) max_burst_o <= cur_burst_nxt;
            end else begin
                cur_burst <= '0;
            end
        end
    end
`else
    assign max_burst_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized + directed bench for viterbi_ber_checker against a queue-based reference model.
// Compile with +define+BER_BURST_STATS_EN to also check burst statistics.
module tb_viterbi_ber_checker;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int SKIP_W = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0, abort_i = 1'b0;
    logic [SKIP_W-1:0] skip_i = '0;
    logic [CNT_W-1:0]  num_check_i = '0;
    logic              ref_valid_i = 1'b0, ref_bit_i = 1'b0;
    logic              dec_valid_i = 1'b0, dec_bit_i = 1'b0;
    logic              busy_o, done_o, mismatch_o, overflow_o, underflow_o;
    logic [CNT_W-1:0]  good_o, bad_o, max_burst_o;

    viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .skip_i(skip_i),
        .num_check_i(num_check_i), .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .busy_o(busy_o), .done_o(done_o),
        .good_o(good_o), .bad_o(bad_o), .mismatch_o(mismatch_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .max_burst_o(max_burst_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: behaviour described directly in terms of a bit queue and integer counts.
    typedef enum {M_IDLE, M_ALIGN, M_RUN, M_DONE} mstate_t;
    mstate_t m_state;
    bit      m_q[$];
    int      m_good, m_bad, m_skip, m_nchk, m_cmp, m_cur, m_max;
    bit      m_ovf, m_unf, m_mis;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic m_reset();
        m_state = M_IDLE; m_q.delete();
        m_good = 0; m_bad = 0; m_skip = 0; m_nchk = 0; m_cmp = 0; m_cur = 0; m_max = 0;
        m_ovf = 0; m_unf = 0; m_mis = 0;
    endtask

    task automatic m_score(input bit miss);
        m_cmp++;
        if (miss) begin
            m_bad = sat(m_bad + 1); m_mis = 1;
            m_cur = sat(m_cur + 1);
            if (m_cur > m_max) m_max = m_cur;
        end else begin
            m_good = sat(m_good + 1); m_cur = 0;
        end
        if (m_nchk != 0 && m_cmp == m_nchk) m_state = M_DONE;
    endtask

    task automatic m_push(input bit b);
        if (m_q.size() >= DEPTH) m_ovf = 1;
        else m_q.push_back(b);
    endtask

    task automatic m_step(input bit st, ab, input int sk, nc, input bit rv, rb, dv, db);
        bit r;
        m_mis = 0;
        if (ab) begin
            m_state = M_IDLE;
            return;
        end
        case (m_state)
            M_IDLE, M_DONE: if (st) begin
                m_good = 0; m_bad = 0; m_ovf = 0; m_unf = 0; m_cur = 0; m_max = 0;
                m_q.delete(); m_skip = sk; m_nchk = nc; m_cmp = 0;
                m_state = (sk == 0) ? M_RUN : M_ALIGN;
            end
            M_ALIGN: begin
                if (rv) m_push(rb);
                if (dv) begin
                    m_skip--;
                    if (m_skip == 0) m_state = M_RUN;
                end
            end
            M_RUN: begin
                if (dv) begin
                    if (m_q.size() != 0) begin
                        r = m_q.pop_front();
                        if (rv) m_q.push_back(rb);
                        m_score(r != db);
                    end else if (rv) m_score(rb != db);
                    else m_unf = 1;
                end else if (rv) m_push(rb);
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        int exp_burst;
`ifdef BER_BURST_STATS_EN
        exp_burst = m_max;
`else
        exp_burst = 0;
`endif
        check({tag, ".busy"}, busy_o, (m_state == M_ALIGN || m_state == M_RUN));
        check({tag, ".done"}, done_o, (m_state == M_DONE));
        check({tag, ".good"}, good_o, m_good);
        check({tag, ".bad"}, bad_o, m_bad);
        check({tag, ".mis"}, mismatch_o, m_mis);
        check({tag, ".ovf"}, overflow_o, m_ovf);
        check({tag, ".unf"}, underflow_o, m_unf);
        check({tag, ".burst"}, max_burst_o, exp_burst);
    endtask

    // Inputs change 1 ns after a rising edge; outputs are compared 1 ns after the next one.
    task automatic cycle(input string tag, input bit st, ab, input int sk, nc,
                         input bit rv, rb, dv, db);
        start_i = st; abort_i = ab; skip_i = SKIP_W'(sk); num_check_i = CNT_W'(nc);
        ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db;
        m_step(st, ab, sk % (1 << SKIP_W), nc % (1 << CNT_W), rv, rb, dv, db);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit ref_bits [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
        bit t4_bits  [5] = '{1, 0, 1, 1, 0};
        int pulses, exp_burst;
        bit b, eh, db;

        m_reset();
        #1;
        compare_all("reset");
        #11 rst = 1'b1;

        // Mid-RUN asynchronous reset with good_o == 5.
        cycle("t1_start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            b = 1'($urandom);
            cycle("t1_run", 0, 0, 0, 0, 1, b, 1, b);
        end
        check("t1_good5", good_o, 5);
        rst = 1'b0;
        m_reset();
        #2;
        compare_all("t1_async");
        #5 rst = 1'b1;
        idle("t1_after");
        check("t1_busy", busy_o, 0);

        // skip 3, 8 compares, all matching, then the same with compared bit 4 inverted.
        for (int t = 0; t < 2; t++) begin
            pulses = 0;
            cycle("t2_start", 1, 0, 3, 8, 0, 0, 0, 0);
            for (int k = 0; k < 11; k++) begin
                db = (k < 3) ? 1'($urandom) : ref_bits[k-3];
                if (t == 1 && k == 7) db = !db;
                cycle("t2_run", 0, 0, 0, 0, (k < 8), (k < 8) ? ref_bits[k] : 1'b0, 1, db);
                if (mismatch_o) pulses++;
                if (k == 9) check("t2_not_done_yet", done_o, 0);
            end
            check(t == 0 ? "t2_good" : "t3_good", good_o, t == 0 ? 8 : 7);
            check(t == 0 ? "t2_bad" : "t3_bad", bad_o, t == 0 ? 0 : 1);
            check(t == 0 ? "t2_done" : "t3_done", done_o, 1);
            check(t == 0 ? "t2_pulses" : "t3_pulses", pulses, t == 0 ? 0 : 1);
        end

        // DEPTH=4 overflow: fifth push dropped, next four pops return the first four bits.
        cycle("t4_start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("t4_push", 0, 0, 0, 0, 1, t4_bits[i], 0, 0);
        check("t4_ovf", overflow_o, 1);
        for (int i = 0; i < 4; i++) cycle("t4_pop", 0, 0, 0, 0, 0, 0, 1, t4_bits[i]);
        check("t4_good", good_o, 4);
        check("t4_bad", bad_o, 0);

        // Bypass compare on empty FIFO, then underflow.
        cycle("t5_abort", 0, 1, 0, 0, 0, 0, 0, 0);
        cycle("t5_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("t5_bypass", 0, 0, 0, 0, 1, 1, 1, 1);
        check("t5_good", good_o, 1);
        cycle("t5_empty", 0, 0, 0, 0, 0, 0, 1, 1);
        check("t5_unf", underflow_o, 1);
        check("t5_good_hold", good_o, 1);
        check("t5_bad_hold", bad_o, 0);

        // Unlimited run saturates good_o; burst pattern x,x,x,ok,x.
        cycle("t6_start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            b = 1'($urandom);
            cycle("t6_match", 0, 0, 0, 0, 1, b, 1, b);
        end
        check("t6_good_sat", good_o, 15);
        check("t6_busy", busy_o, 1);
        for (int i = 0; i < 5; i++) begin
            b = 1'($urandom);
            cycle("t6_burst", 0, 0, 0, 0, 1, b, 1, (i == 3) ? b : !b);
        end
`ifdef BER_BURST_STATS_EN
        exp_burst = 3;
`else
        exp_burst = 0;
`endif
        check("t6_max_burst", max_burst_o, exp_burst);
        check("t6_bad", bad_o, 4);

        // Abort beats start in the same cycle.
        cycle("abort_vs_start", 1, 1, 0, 0, 0, 0, 0, 0);
        check("abort_idle", busy_o, 0);

        // Randomized sessions.
        for (int run = 0; run < 60; run++) begin
            if (m_state == M_IDLE || m_state == M_DONE)
                cycle("rnd_start", 1, 0, $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12), 0, 0, 0, 0);
            for (int c = 0; c < 40; c++) begin
                bit rv, dv, st, ab;
                rv = ($urandom_range(0, 3) != 0);
                dv = ($urandom_range(0, 3) != 0);
                b  = 1'($urandom);
                eh = (m_q.size() != 0) ? m_q[0] : b;
                db = ($urandom_range(0, 4) == 0) ? !eh : eh;
                st = ($urandom_range(0, 15) == 0);
                ab = ($urandom_range(0, 99) == 0);
                cycle("rnd", st, ab, $urandom_range(0, 15), $urandom_range(0, 15), rv, b, dv, db);
                if (m_state == M_IDLE || m_state == M_DONE) break;
            end
            if (m_state != M_IDLE && m_state != M_DONE)
                cycle("rnd_abort", 0, 1, 0, 0, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
